// File: rtl/stack_game_pkg.sv
// Shared encodings for the two-player stacking game scheduler: FSM states,
// reported game/winner codes, side identifiers and command bit positions.
package stack_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GRANT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam logic [1:0] GAME_IDLE = 2'b00;
  localparam logic [1:0] GAME_RUN  = 2'b01;
  localparam logic [1:0] GAME_OVER = 2'b10;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int CMD_N      = 6;
  localparam int CMD_RESET  = 0;
  localparam int CMD_START  = 1;
  localparam int CMD_LDROP  = 2;
  localparam int CMD_RDROP  = 3;
  localparam int CMD_LSPEED = 4;
  localparam int CMD_RSPEED = 5;

  function automatic logic [1:0] win_code(input logic side);
    return (side == SIDE_R) ? WIN_RIGHT : WIN_LEFT;
  endfunction

endpackage

// File: rtl/stack_game_scheduler_cmd_edge_detect.sv
// Rising-edge detector for the level-style keyboard command flags; a held key
// yields a single one-cycle event.
module cmd_edge_detect #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] event_o
);

  logic [N-1:0] prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prev_q <= '0;
    else         prev_q <= in_i;
  end

  assign event_o = in_i & ~prev_q;

endmodule

// File: rtl/stack_game_scheduler.sv
// Game sequencer: shares one drop engine between the left and right players
// round-robin, and tracks heights, speed levels, game state and winner.
module stack_game_scheduler
  import stack_game_pkg::*;
#(
  parameter  int MAX_HEIGHT   = 15,
  parameter  int SPEED_LEVELS = 4,
  parameter  int TIMEOUT_CYC  = 50_000_000,
  localparam int HEIGHT_W     = $clog2(MAX_HEIGHT + 1),
  localparam int SPD_W        = $clog2(SPEED_LEVELS),
  localparam int TO_W         = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_reset,
  input  logic                cmd_start,
  input  logic                cmd_left_drop,
  input  logic                cmd_right_drop,
  input  logic                cmd_left_speed,
  input  logic                cmd_right_speed,
  input  logic                eng_busy,
  input  logic                eng_done,
  input  logic                eng_miss,
  output logic                eng_start,
  output logic                eng_side,
  output logic [SPD_W-1:0]    eng_speed,
  output logic                eng_abort,
  output logic [1:0]          game_state,
  output logic [1:0]          winner,
  output logic [HEIGHT_W-1:0] left_height,
  output logic [HEIGHT_W-1:0] right_height,
  output logic [SPD_W-1:0]    left_speed,
  output logic [SPD_W-1:0]    right_speed,
  output logic                err_timeout
);

  logic [CMD_N-1:0] ev;

  cmd_edge_detect #(.N(CMD_N)) u_edge (
    .clk     (clk),
    .resetn  (resetn),
    .in_i    ({cmd_right_speed, cmd_left_speed, cmd_right_drop,
               cmd_left_drop, cmd_start, cmd_reset}),
    .event_o (ev)
  );

  state_e              state_q, state_d;
  logic                pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                last_q, last_d, side_q, side_d;
  logic [SPD_W-1:0]    speed_q, speed_d, sl_q, sl_d, sr_q, sr_d;
  logic [HEIGHT_W-1:0] hl_q, hl_d, hr_q, hr_d;
  logic [1:0]          win_q, win_d;
  logic                err_q, err_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                gnt_c, active_c;
  logic [HEIGHT_W-1:0] nh_c;

  function automatic logic [SPD_W-1:0] spd_inc(input logic [SPD_W-1:0] s);
    return (s == SPD_W'(SPEED_LEVELS - 1)) ? '0 : s + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    pend_l_d  = pend_l_q;
    pend_r_d  = pend_r_q;
    last_d    = last_q;
    side_d    = side_q;
    speed_d   = speed_q;
    hl_d      = hl_q;
    hr_d      = hr_q;
    sl_d      = sl_q;
    sr_d      = sr_q;
    win_d     = win_q;
    err_d     = err_q;
    to_d      = to_q;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    gnt_c     = SIDE_L;
    nh_c      = '0;
    active_c  = (state_q == ST_RUN) || (state_q == ST_GRANT) || (state_q == ST_WAIT);

    if (ev[CMD_RESET]) begin
      eng_abort = (state_q == ST_GRANT) || (state_q == ST_WAIT);
      state_d   = ST_IDLE;
      pend_l_d  = 1'b0;
      pend_r_d  = 1'b0;
      last_d    = SIDE_R;
      side_d    = SIDE_L;
      speed_d   = '0;
      hl_d      = '0;
      hr_d      = '0;
      sl_d      = '0;
      sr_d      = '0;
      win_d     = WIN_NONE;
      err_d     = 1'b0;
      to_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (ev[CMD_START]) begin
            state_d  = ST_RUN;
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
            hl_d     = '0;
            hr_d     = '0;
            sl_d     = '0;
            sr_d     = '0;
            win_d    = WIN_NONE;
            err_d    = 1'b0;
          end
        end
        // Launch only into an idle engine; the side's current level rides with the drop.
        ST_RUN: begin
          if ((pend_l_q || pend_r_q) && !eng_busy) begin
            gnt_c   = (pend_l_q && pend_r_q) ? ~last_q : pend_r_q;
            side_d  = gnt_c;
            speed_d = (gnt_c == SIDE_R) ? sr_q : sl_q;
            state_d = ST_GRANT;
          end
        end
        ST_GRANT: begin
          eng_start = 1'b1;
          to_d      = '0;
          last_d    = side_q;
          if (side_q == SIDE_R) pend_r_d = 1'b0;
          else                  pend_l_d = 1'b0;
          state_d   = ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            if (eng_miss) begin
              win_d   = win_code(~side_q);
              state_d = ST_OVER;
            end else begin
              nh_c = ((side_q == SIDE_R) ? hr_q : hl_q) + 1'b1;
              if (side_q == SIDE_R) hr_d = nh_c;
              else                  hl_d = nh_c;
              if (nh_c == HEIGHT_W'(MAX_HEIGHT)) begin
                win_d   = win_code(side_q);
                state_d = ST_OVER;
              end else begin
                state_d = ST_RUN;
              end
            end
          end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
            eng_abort = 1'b1;
            err_d     = 1'b1;
            state_d   = ST_RUN;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Applied after the grant clear so a same-side drop in the GRANT cycle re-arms the flag.
      if (active_c) begin
        if (ev[CMD_LDROP])  pend_l_d = 1'b1;
        if (ev[CMD_RDROP])  pend_r_d = 1'b1;
        if (ev[CMD_LSPEED]) sl_d = spd_inc(sl_q);
        if (ev[CMD_RSPEED]) sr_d = spd_inc(sr_q);
      end
      if (state_d == ST_OVER && state_q != ST_OVER) begin
        pend_l_d = 1'b0;
        pend_r_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      last_q   <= SIDE_R;
      side_q   <= SIDE_L;
      speed_q  <= '0;
      hl_q     <= '0;
      hr_q     <= '0;
      sl_q     <= '0;
      sr_q     <= '0;
      win_q    <= WIN_NONE;
      err_q    <= 1'b0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      last_q   <= last_d;
      side_q   <= side_d;
      speed_q  <= speed_d;
      hl_q     <= hl_d;
      hr_q     <= hr_d;
      sl_q     <= sl_d;
      sr_q     <= sr_d;
      win_q    <= win_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    game_state = GAME_IDLE;
    case (state_q)
      ST_RUN, ST_GRANT, ST_WAIT: game_state = GAME_RUN;
      ST_OVER:                   game_state = GAME_OVER;
      default:                   game_state = GAME_IDLE;
    endcase
  end

  assign eng_side     = side_q;
  assign eng_speed    = speed_q;
  assign winner       = win_q;
  assign left_height  = hl_q;
  assign right_height = hr_q;
  assign left_speed   = sl_q;
  assign right_speed  = sr_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_stack_game_scheduler.sv
// Directed and randomized bench for stack_game_scheduler; the bench plays the
// drop engine and predicts results from a game-level model of the rules.
module tb_stack_game_scheduler;

  localparam int MAXH = 15;
  localparam int LV   = 4;
  localparam int TO   = 20;

  localparam logic [5:0] M_RESET = 6'b000001;
  localparam logic [5:0] M_START = 6'b000010;
  localparam logic [5:0] M_LDROP = 6'b000100;
  localparam logic [5:0] M_RDROP = 6'b001000;
  localparam logic [5:0] M_LSPD  = 6'b010000;
  localparam logic [5:0] M_RSPD  = 6'b100000;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] cmdVec;
  logic       eng_busy, eng_done, eng_miss;
  logic       eng_start, eng_side, eng_abort, err_timeout;
  logic [1:0] eng_speed, game_state, winner, left_speed, right_speed;
  logic [3:0] left_height, right_height;

  int errors = 0;
  int checks = 0;

  int mH[2];
  int mS[2];
  bit mPend[2];
  int mLast;
  int mWin;
  int mGame;
  int mErr;

  stack_game_scheduler #(.MAX_HEIGHT(MAXH), .SPEED_LEVELS(LV), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .cmd_reset       (cmdVec[0]),
    .cmd_start       (cmdVec[1]),
    .cmd_left_drop   (cmdVec[2]),
    .cmd_right_drop  (cmdVec[3]),
    .cmd_left_speed  (cmdVec[4]),
    .cmd_right_speed (cmdVec[5]),
    .eng_busy        (eng_busy),
    .eng_done        (eng_done),
    .eng_miss        (eng_miss),
    .eng_start       (eng_start),
    .eng_side        (eng_side),
    .eng_speed       (eng_speed),
    .eng_abort       (eng_abort),
    .game_state      (game_state),
    .winner          (winner),
    .left_height     (left_height),
    .right_height    (right_height),
    .left_speed      (left_speed),
    .right_speed     (right_speed),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] mask);
    cmdVec = cmdVec | mask;
    tick(1);
    cmdVec = cmdVec & ~mask;
    tick(1);
  endtask

  function automatic void modelClear(input bit hard);
    mH = '{0, 0};
    mS = '{0, 0};
    mPend = '{1'b0, 1'b0};
    mWin = 0;
    mErr = 0;
    mGame = hard ? 0 : 1;
    if (hard) mLast = 1;
  endfunction

  function automatic void modelDrop(input int s);
    if (mGame == 1) mPend[s] = 1'b1;
  endfunction

  function automatic void modelSpeed(input int s);
    if (mGame == 1) mS[s] = (mS[s] + 1) % LV;
  endfunction

  function automatic int modelGrant();
    int s;
    s = (mPend[0] && mPend[1]) ? 1 - mLast : (mPend[1] ? 1 : 0);
    mPend[s] = 1'b0;
    mLast = s;
    return s;
  endfunction

  function automatic void modelDone(input int s, input bit miss);
    if (miss) begin
      mWin = (1 - s) + 1;
    end else begin
      mH[s] = mH[s] + 1;
      if (mH[s] == MAXH) mWin = s + 1;
    end
    if (mWin != 0) begin
      mGame = 2;
      mPend = '{1'b0, 1'b0};
    end
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "/left_height"}, left_height, mH[0]);
    checkOutput({tag, "/right_height"}, right_height, mH[1]);
    checkOutput({tag, "/left_speed"}, left_speed, mS[0]);
    checkOutput({tag, "/right_speed"}, right_speed, mS[1]);
    checkOutput({tag, "/game_state"}, game_state, mGame);
    checkOutput({tag, "/winner"}, winner, mWin);
    checkOutput({tag, "/err_timeout"}, err_timeout, mErr);
  endtask

  task automatic waitStart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (eng_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick(1);
    end
    checkOutput("eng_start_wait", eng_start, 1);
  endtask

  // Engine emulation: grant checked against the model, then done after a short random flight.
  task automatic serviceDrop(input bit miss);
    bit ok;
    int s;
    waitStart(ok);
    if (!ok) return;
    s = modelGrant();
    checkOutput("eng_side", eng_side, s);
    checkOutput("eng_speed", eng_speed, mS[s]);
    eng_busy = 1'b1;
    tick(1);
    checkOutput("eng_start_pulse", eng_start, 0);
    tick($urandom_range(0, 4));
    eng_done = 1'b1;
    eng_miss = miss;
    eng_busy = 1'b0;
    tick(1);
    eng_done = 1'b0;
    eng_miss = 1'b0;
    modelDone(s, miss);
  endtask

  initial begin
    bit ok;
    int cnt;
    int s;
    cmdVec   = '0;
    eng_busy = 1'b0;
    eng_done = 1'b0;
    eng_miss = 1'b0;
    resetn   = 1'b0;
    modelClear(1'b1);
    tick(2);
    checkState("reset");
    checkOutput("reset/eng_start", eng_start, 0);
    checkOutput("reset/eng_abort", eng_abort, 0);
    checkOutput("reset/eng_side", eng_side, 0);
    checkOutput("reset/eng_speed", eng_speed, 0);
    resetn = 1'b1;
    tick(1);

    applyStimulus(M_START);
    modelClear(1'b0);
    checkOutput("start/game_state", game_state, 1);

    // Simultaneous drops: left wins the first tie, right follows.
    applyStimulus(M_LDROP | M_RDROP);
    modelDrop(0);
    modelDrop(1);
    serviceDrop(1'b0);
    checkState("both_first");
    serviceDrop(1'b0);
    checkState("both_second");

    cmdVec[2] = 1'b1;
    modelDrop(0);
    serviceDrop(1'b0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (eng_start === 1'b1) cnt++;
    end
    checkOutput("held_key_extra_starts", cnt, 0);
    cmdVec[2] = 1'b0;
    tick(1);
    checkState("held_key");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(M_RSPD);
      modelSpeed(1);
    end
    checkOutput("right_speed_wrap", right_speed, 1);
    applyStimulus(M_RDROP);
    modelDrop(1);
    serviceDrop(1'b0);
    checkState("speed_grant");

    for (int it = 0; it < 30; it++) begin
      int r;
      if (mGame != 1) begin
        applyStimulus(M_START);
        modelClear(1'b0);
        checkState("rand_restart");
      end
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, 1);
        applyStimulus(s == 1 ? M_RSPD : M_LSPD);
        modelSpeed(s);
      end
      r = $urandom_range(0, 2);
      applyStimulus(r == 0 ? M_LDROP : (r == 1 ? M_RDROP : (M_LDROP | M_RDROP)));
      if (r != 1) modelDrop(0);
      if (r != 0) modelDrop(1);
      while ((mPend[0] || mPend[1]) && mGame == 1) begin
        serviceDrop($urandom_range(0, 19) == 0);
        checkState("rand");
      end
    end

    applyStimulus(M_RESET);
    modelClear(1'b1);
    checkState("soft_reset");
    applyStimulus(M_START);
    modelClear(1'b0);
    for (int i = 0; i < MAXH; i++) begin
      applyStimulus(M_LDROP);
      modelDrop(0);
      serviceDrop(1'b0);
    end
    checkOutput("win/left_height", left_height, 15);
    checkOutput("win/winner", winner, 1);
    checkOutput("win/game_state", game_state, 2);
    cmdVec[2] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (eng_start === 1'b1) cnt++;
    end
    cmdVec[2] = 1'b0;
    tick(1);
    checkOutput("over_drop_starts", cnt, 0);
    checkState("over_drop");
    applyStimulus(M_START);
    modelClear(1'b0);
    checkOutput("restart/left_height", left_height, 0);
    checkState("restart");

    applyStimulus(M_RDROP);
    modelDrop(1);
    serviceDrop(1'b1);
    checkOutput("miss/winner", winner, 1);
    checkOutput("miss/game_state", game_state, 2);

    applyStimulus(M_START);
    modelClear(1'b0);
    applyStimulus(M_LDROP);
    modelDrop(0);
    waitStart(ok);
    s = modelGrant();
    eng_busy = 1'b1;
    cnt = 0;
    while (cnt < 40 && eng_abort !== 1'b1) begin
      tick(1);
      cnt++;
    end
    checkOutput("timeout_cycle", cnt, TO);
    eng_busy = 1'b0;
    tick(1);
    mErr = 1;
    checkState("timeout");

    applyStimulus(M_LDROP);
    modelDrop(0);
    waitStart(ok);
    s = modelGrant();
    eng_busy = 1'b1;
    tick(3);
    cmdVec[0] = 1'b1;
    #1;
    checkOutput("esc_wait/eng_abort", eng_abort, 1);
    tick(1);
    cmdVec[0] = 1'b0;
    eng_busy = 1'b0;
    modelClear(1'b1);
    tick(1);
    checkState("esc_wait");

    applyStimulus(M_START);
    modelClear(1'b0);
    applyStimulus(M_LDROP);
    modelDrop(0);
    waitStart(ok);
    s = modelGrant();
    eng_busy = 1'b1;
    tick(2);
    resetn = 1'b0;
    #1;
    modelClear(1'b1);
    checkState("hard_reset");
    checkOutput("hard_reset/eng_abort", eng_abort, 0);
    checkOutput("hard_reset/eng_speed", eng_speed, 0);
    eng_busy = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(1);
    applyStimulus(M_START);
    modelClear(1'b0);
    checkOutput("hard_reset_start/game_state", game_state, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
